// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory round-robin arbiter: FSM encoding and
// the data/address widths of the 16x16 SRAM macro it fronts.
package mem_arb_pkg;

    localparam int MEM_WIDTH      = 16;
    localparam int MEM_ADDR_WIDTH = 4;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = IDLE,
        S_ISSUE = ISSUE,
        S_WAIT  = WAIT,
        S_RESP  = RESP
    } arb_state_e;

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Requester-side and memory-side buses of the arbiter. The slave modport is the
// arbiter's view; the master modport is the clients-plus-memory environment.
interface mem_rr_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) ();

    // Handshake: a requester holds req_valid_i[k] until req_ready_o[k] pulses for
    // one cycle; the memory accepts a one-cycle mem_valid_o and later answers
    // with mem_ready_i, with mem_rdata_i valid in that same cycle.
    logic [NUM_REQ-1:0]            req_valid_i;
    logic [NUM_REQ-1:0]            req_wr_rd_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
    logic [NUM_REQ*WIDTH-1:0]      req_wdata_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic [WIDTH-1:0]              req_rdata_o;
    logic                          req_err_o;
    logic [NUM_REQ-1:0]            grant_o;
    logic                          mem_valid_o;
    logic                          mem_wr_rd_o;
    logic [ADDR_WIDTH-1:0]         mem_addr_o;
    logic [WIDTH-1:0]              mem_wdata_o;
    logic                          mem_ready_i;
    logic [WIDTH-1:0]              mem_rdata_i;

    modport slave (
        input  req_valid_i, req_wr_rd_i, req_addr_i, req_wdata_i,
        output req_ready_o, req_rdata_o, req_err_o, grant_o,
        output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i
    );

    modport master (
        output req_valid_i, req_wr_rd_i, req_addr_i, req_wdata_i,
        input  req_ready_o, req_rdata_o, req_err_o, grant_o,
        input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; finds the first set request at or
// above ptr (with wrap) and returns it one-hot plus its index.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] index,
    output logic                       found
);

    localparam int IDXW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] rotated;
    logic [IDXW:0]      sum;

    // Rotating by ptr turns the wrap-around search into a plain lowest-bit search.
    assign rotated = NUM_REQ'({req, req} >> ptr);

    always_comb begin
        found = 1'b0;
        sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && rotated[i]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IDXW+1)'(i);
            end
        end
        index = (sum >= (IDXW+1)'(NUM_REQ)) ? IDXW'(sum - (IDXW+1)'(NUM_REQ))
                                            : sum[IDXW-1:0];
        grant = found ? (NUM_REQ'(1) << index) : '0;
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready SRAM between NUM_REQ requesters.
// Optional WAIT timeout with error response: define MEM_RR_ARBITER_TIMEOUT_EN.
module mem_rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = MEM_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic             clk_i,
    input  logic             rst_i,
    mem_rr_arbiter_if.slave  bus,
    output arb_state_e       state_o
);

    localparam int IDXW = $clog2(NUM_REQ);

    arb_state_e            state;
    logic [IDXW-1:0]       ptr, gidx, pick_idx;
    logic [NUM_REQ-1:0]    grant, req_ready, pick_gnt;
    logic                  pick_any;
    logic                  mem_valid, mem_wr_rd;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata, rdata;
    logic                  sel_wr_rd;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0]      sel_wdata;

`ifdef MEM_RR_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] timer;
    logic          err;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req_valid_i),
        .ptr   (ptr),
        .grant (pick_gnt),
        .index (pick_idx),
        .found (pick_any)
    );

    always_comb begin
        sel_wr_rd = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_gnt[k]) begin
                sel_wr_rd = bus.req_wr_rd_i[k];
                sel_addr  = bus.req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            grant     <= '0;
            req_ready <= '0;
            mem_valid <= 1'b0;
            mem_wr_rd <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
            timer     <= '0;
            err       <= 1'b0;
`endif
        end else begin
            mem_valid <= 1'b0;
            req_ready <= '0;
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
            err       <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    // The mem_* registers double as the capture registers.
                    if (pick_any) begin
                        grant     <= pick_gnt;
                        gidx      <= pick_idx;
                        mem_wr_rd <= sel_wr_rd;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_valid <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
                    timer <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_ready_i) begin
                        if (!mem_wr_rd) rdata <= bus.mem_rdata_i;
                        req_ready <= grant;
                        state     <= S_RESP;
                    end
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
                    else if (timer == TW'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        req_ready <= grant;
                        state     <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    grant <= '0;
                    ptr   <= (gidx == IDXW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.req_rdata_o = rdata;
    assign bus.grant_o     = grant;
    assign bus.mem_valid_o = mem_valid;
    assign bus.mem_wr_rd_o = mem_wr_rd;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign state_o         = state;

`ifdef MEM_RR_ARBITER_TIMEOUT_EN
    assign bus.req_err_o = err;
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign bus.req_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural 16x16 valid/ready SRAM
// that answers one cycle after mem_valid_o unless stalled.
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int AW = 4;
  localparam int TO = 15;

  logic       clk_i, rst_i;
  arb_state_e state;
  logic       mem_stall, mem_force_ready;
  logic [W-1:0] mem_arr [16];
  int errors, checks;

  mem_rr_arbiter_if #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  mem_rr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (state)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (bus.mem_valid_o) begin
      if (bus.mem_wr_rd_o) mem_arr[bus.mem_addr_o] <= bus.mem_wdata_o;
      else bus.mem_rdata_i <= mem_arr[bus.mem_addr_o];
      bus.mem_ready_i <= !mem_stall;
    end else begin
      bus.mem_ready_i <= mem_force_ready;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b0;
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
  endtask

  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] wd);
    bus.req_wr_rd_i[k] = wr;
    bus.req_addr_i[k*AW +: AW] = addr;
    bus.req_wdata_i[k*W +: W] = wd;
    bus.req_valid_i[k] = 1'b1;
  endtask

  // One transaction from requester k, started in IDLE; ends back in IDLE.
  task automatic run_txn(input int k, input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] wd,
                         output int lat, output logic [NR-1:0] rdy, output logic [NR-1:0] gnt,
                         output logic [W-1:0] rd, output logic err, output int vcnt,
                         output logic [20:0] issued, output logic rd_moved);
    logic [W-1:0] start;
    start = bus.req_rdata_o;
    lat = 0; rdy = '0; gnt = '0; rd = '0; err = 1'b0; vcnt = 0; issued = '0; rd_moved = 1'b0;
    set_req(k, wr, addr, wd);
    while (lat < 40 && rdy == '0) begin
      tick();
      lat++;
      if (gnt == '0) gnt = bus.grant_o;
      if (bus.mem_valid_o) begin
        vcnt++;
        issued = {bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o};
      end
      if (bus.req_rdata_o !== start && bus.req_ready_o == '0) rd_moved = 1'b1;
      if (bus.req_ready_o != '0) begin
        rdy = bus.req_ready_o;
        rd  = bus.req_rdata_o;
        err = bus.req_err_o;
      end
    end
    bus.req_valid_i[k] = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
    checks++; if (bus.req_ready_o !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready_o); end
    checks++; if (bus.grant_o !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", bus.grant_o); end
    checks++; if ({bus.req_err_o, bus.req_rdata_o} !== 17'h0) begin errors++; $display("FAIL reset_resp: got err=%b rdata=%h expected 0", bus.req_err_o, bus.req_rdata_o); end
    checks++; if ({bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o} !== 22'h0) begin errors++; $display("FAIL reset_mem: got %b %b %h %h expected 0", bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o); end
    rst_i = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    int lat, vcnt; logic [NR-1:0] rdy, gnt; logic [W-1:0] rd; logic err, mv; logic [20:0] iss;
    run_txn(1, 1'b1, 4'd5, 16'hA5A5, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL wr_ready: got %b expected 0010", rdy); end
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wr_grant: got %b expected 0010", gnt); end
    checks++; if (vcnt !== 1) begin errors++; $display("FAIL wr_valid_pulse: got %0d cycles expected 1", vcnt); end
    checks++; if (iss !== {1'b1, 4'h5, 16'hA5A5}) begin errors++; $display("FAIL wr_issue: got %h expected %h", iss, {1'b1, 4'h5, 16'hA5A5}); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", err); end
    run_txn(1, 1'b0, 4'd5, 16'h0000, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rdy !== 4'b0010) begin errors++; $display("FAIL rd_ready: got %b expected 0010", rdy); end
    checks++; if (iss !== {1'b0, 4'h5, 16'h0000}) begin errors++; $display("FAIL rd_issue: got %h expected %h", iss, {1'b0, 4'h5, 16'h0000}); end
    checks++; if (rd !== 16'hA5A5) begin errors++; $display("FAIL rd_data: got %h expected a5a5", rd); end
  endtask

  task automatic test_contention();
    int cyc, n, bad; logic [NR-1:0] exp_r;
    apply_reset();
    for (int k = 0; k < NR; k++) set_req(k, 1'b0, 4'd5, 16'h0000);
    cyc = 0; n = 0; bad = 0;
    while (n < 4 && cyc < 40) begin
      tick();
      cyc++;
      if (bus.grant_o != '0 && !$onehot(bus.grant_o)) bad++;
      if (bus.req_ready_o != '0) begin
        exp_r = 4'b0001 << n;
        checks++; if (bus.req_ready_o !== exp_r) begin errors++; $display("FAIL cont_order: pulse %0d got %b expected %b", n, bus.req_ready_o, exp_r); end
        checks++; if (cyc !== 3 + 4*n) begin errors++; $display("FAIL cont_timing: pulse %0d at cycle %0d expected %0d", n, cyc, 3 + 4*n); end
        checks++; if (bus.req_rdata_o !== 16'hA5A5) begin errors++; $display("FAIL cont_data: got %h expected a5a5", bus.req_rdata_o); end
        bus.req_valid_i[n] = 1'b0;
        n++;
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL cont_count: got %0d pulses expected 4", n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL cont_onehot: got %0d bad cycles expected 0", bad); end
    bus.req_valid_i = '0;
    tick();
  endtask

  task automatic test_wrap();
    int cyc, n; logic [NR-1:0] exp_r;
    set_req(0, 1'b0, 4'd5, 16'h0000);
    set_req(3, 1'b0, 4'd5, 16'h0000);
    cyc = 0; n = 0;
    while (n < 8 && cyc < 60) begin
      tick();
      cyc++;
      if (bus.req_ready_o != '0) begin
        exp_r = (n % 2 == 0) ? 4'b0001 : 4'b1000;
        checks++; if (bus.req_ready_o !== exp_r) begin errors++; $display("FAIL wrap_order: pulse %0d got %b expected %b", n, bus.req_ready_o, exp_r); end
        checks++; if (cyc !== 3 + 4*n) begin errors++; $display("FAIL wrap_timing: pulse %0d at cycle %0d expected %0d", n, cyc, 3 + 4*n); end
        n++;
      end
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL wrap_count: got %0d pulses expected 8", n); end
    bus.req_valid_i = '0;
    tick();
  endtask

  task automatic test_write_holds_rdata();
    int lat, vcnt; logic [NR-1:0] rdy, gnt; logic [W-1:0] rd; logic err, mv; logic [20:0] iss;
    run_txn(2, 1'b1, 4'd2, 16'h1234, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    run_txn(2, 1'b0, 4'd2, 16'h0000, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (rd !== 16'h1234) begin errors++; $display("FAIL hold_read: got %h expected 1234", rd); end
    run_txn(0, 1'b1, 4'd7, 16'hBEEF, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (rdy !== 4'b0001) begin errors++; $display("FAIL hold_wr_ready: got %b expected 0001", rdy); end
    checks++; if (mv !== 1'b0 || rd !== 16'h1234) begin errors++; $display("FAIL hold_during_write: got moved=%b rdata=%h expected 0/1234", mv, rd); end
    checks++; if (bus.req_rdata_o !== 16'h1234) begin errors++; $display("FAIL hold_after_write: got %h expected 1234", bus.req_rdata_o); end
    run_txn(0, 1'b0, 4'd7, 16'h0000, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL hold_read_back: got %h expected beef", rd); end
  endtask

  task automatic test_drop_after_grant();
    int lat, vcnt, cyc; logic [NR-1:0] rdy, gnt; logic [W-1:0] rd; logic err, mv; logic [20:0] iss;
    set_req(1, 1'b1, 4'd9, 16'h5555);
    tick();
    checks++; if (bus.grant_o !== 4'b0010) begin errors++; $display("FAIL drop_grant: got %b expected 0010", bus.grant_o); end
    bus.req_valid_i[1] = 1'b0;
    bus.req_addr_i[1*AW +: AW] = 4'd0;
    bus.req_wdata_i[1*W +: W] = 16'h0000;
    tick();
    checks++; if ({bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b0, 1'b1, 4'h9, 16'h5555}) begin
      errors++; $display("FAIL drop_wait_hold: got %b %b %h %h expected 0 1 9 5555", bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o);
    end
    cyc = 0;
    while (bus.req_ready_o == '0 && cyc < 10) begin tick(); cyc++; end
    checks++; if (bus.req_ready_o !== 4'b0010) begin errors++; $display("FAIL drop_ready: got %b expected 0010", bus.req_ready_o); end
    tick();
    run_txn(1, 1'b0, 4'd9, 16'h0000, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (rd !== 16'h5555) begin errors++; $display("FAIL drop_landed: got %h expected 5555", rd); end
  endtask

  task automatic test_ready_outside_wait();
    int bad;
    bad = 0;
    mem_force_ready = 1'b1;
    repeat (4) begin
      tick();
      if (bus.req_ready_o != '0 || bus.grant_o != '0 || state != S_IDLE) bad++;
    end
    mem_force_ready = 1'b0;
    tick();
    checks++; if (bad !== 0) begin errors++; $display("FAIL idle_ready_ignored: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid_wait();
    int lat, vcnt, cyc, bad; logic [NR-1:0] rdy, gnt; logic [W-1:0] rd; logic err, mv; logic [20:0] iss;
    run_txn(2, 1'b0, 4'd5, 16'h0000, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    mem_stall = 1'b1;
    set_req(3, 1'b0, 4'd5, 16'h0000);
    repeat (2) tick();
    checks++; if (state !== S_WAIT) begin errors++; $display("FAIL rst_in_wait: got state %0d expected %0d", state, S_WAIT); end
    rst_i = 1'b0;
    #1;
    checks++; if ({bus.req_ready_o, bus.grant_o, bus.req_err_o, bus.req_rdata_o} !== 25'h0 || state !== S_IDLE) begin
      errors++; $display("FAIL rst_async_clear: got ready=%b grant=%b rdata=%h state=%0d expected 0", bus.req_ready_o, bus.grant_o, bus.req_rdata_o, state);
    end
    checks++; if ({bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o} !== 22'h0) begin errors++; $display("FAIL rst_async_mem: got %b %h expected 0", bus.mem_valid_o, bus.mem_addr_o); end
    bad = 0;
    repeat (3) begin tick(); if (bus.req_ready_o != '0) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rst_no_pulse: got %0d pulses expected 0", bad); end
    rst_i = 1'b1;
    mem_stall = 1'b0;
    set_req(1, 1'b0, 4'd5, 16'h0000);
    cyc = 0;
    while (bus.req_ready_o == '0 && cyc < 10) begin tick(); cyc++; end
    checks++; if (bus.req_ready_o !== 4'b0010 || cyc !== 3) begin errors++; $display("FAIL rst_ptr_zero: got %b at cycle %0d expected 0010 at 3", bus.req_ready_o, cyc); end
    bus.req_valid_i[1] = 1'b0;
    tick();
    cyc = 0;
    while (bus.req_ready_o == '0 && cyc < 10) begin tick(); cyc++; end
    checks++; if (bus.req_ready_o !== 4'b1000) begin errors++; $display("FAIL rst_next: got %b expected 1000", bus.req_ready_o); end
    bus.req_valid_i[3] = 1'b0;
    tick();
  endtask

`ifdef MEM_RR_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int lat, vcnt; logic [NR-1:0] rdy, gnt; logic [W-1:0] rd; logic err, mv; logic [20:0] iss;
    mem_stall = 1'b1;
    run_txn(0, 1'b0, 4'd7, 16'h0000, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (lat !== TO + 2) begin errors++; $display("FAIL to_latency: got %0d expected %0d", lat, TO + 2); end
    checks++; if (rdy !== 4'b0001 || err !== 1'b1) begin errors++; $display("FAIL to_err: got ready=%b err=%b expected 0001/1", rdy, err); end
    checks++; if (rd !== 16'hA5A5) begin errors++; $display("FAIL to_rdata_kept: got %h expected a5a5", rd); end
    mem_stall = 1'b0;
    run_txn(1, 1'b0, 4'd7, 16'h0000, lat, rdy, gnt, rd, err, vcnt, iss, mv);
    checks++; if (err !== 1'b0 || rd !== 16'hBEEF) begin errors++; $display("FAIL to_normal: got err=%b rdata=%h expected 0/beef", err, rd); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    rst_i = 1'b0;
    mem_stall = 1'b0;
    mem_force_ready = 1'b0;
    bus.req_valid_i = '0;
    bus.req_wr_rd_i = '0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    test_reset();
    test_write_read();
    test_contention();
    test_wrap();
    test_write_holds_rdata();
    test_drop_after_grant();
    test_ready_outside_wait();
    test_reset_mid_wait();
`ifdef MEM_RR_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
